// File: rtl/cptra_apb_init_pkg.sv
// Shared types and defaults for the Caliptra APB initiator.
//   state_e : FSM states (IDLE/SETUP/ACCESS/RESP)
//   rsp_t   : captured response payload {rdata, slverr, timeout, latency}
//   tmr_width() : timeout counter width, $clog2(limit+1) with a floor of 1
package cptra_apb_init_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned LAT_W              = 16;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // rdata is sized to the default bus width; wider DATA_WIDTH values are truncated.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
    logic [LAT_W-1:0]          latency;
  } rsp_t;

  function automatic int unsigned tmr_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cptra_apb_init_timer.sv
// ACCESS-phase timer: timeout limit detect plus saturating latency count.
//   clk, rst_n     : clock, async active-low reset
//   i_clr          : clear both counters (asserted while in SETUP)
//   i_en           : count one wait cycle (ACCESS with PREADY low)
//   o_limit_c      : timeout counter sits at TIMEOUT_CYCLES-1 (never when disabled)
//   o_lat_next_c   : latency value to report if the transfer ends this cycle
module cptra_apb_init_timer
  import cptra_apb_init_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_limit_c,
  output logic [LAT_W-1:0] o_lat_next_c
);

  localparam int unsigned      TMR_W    = tmr_width(TIMEOUT_CYCLES);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;
  logic [LAT_W-1:0] r_lat;

  // Both counters stop rather than wrap; the FSM leaves ACCESS at the limit anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
      r_lat <= '0;
    end else if (i_clr) begin
      r_tmr <= '0;
      r_lat <= '0;
    end else if (i_en) begin
      if (TMO_EN && (r_tmr != TMR_LAST)) r_tmr <= r_tmr + TMR_W'(1);
      if (r_lat != LAT_MAX)              r_lat <= r_lat + LAT_W'(1);
    end
  end

  assign o_limit_c    = TMO_EN && (r_tmr == TMR_LAST);
  assign o_lat_next_c = (r_lat == LAT_MAX) ? LAT_MAX : (r_lat + LAT_W'(1));

endmodule

// File: rtl/cptra_apb_initiator.sv
// APB requester for Caliptra's APB responder port (FPGA).
// Single outstanding command: request channel -> SETUP -> ACCESS -> response channel.
//   core_clk, cptra_rst_b        : clock, async active-low reset
//   req_*                        : command channel (req_ready = idle)
//   rsp_*                        : response channel, fields held until rsp_ready
//   busy                         : transfer in flight or response pending
//   PADDR..PSTRB, PRDATA..PSLVERR: APB requester interface
// A bounded ACCESS wait aborts a hung PREADY (debug aid; violates APB on purpose).
module cptra_apb_initiator
  import cptra_apb_init_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    core_clk,
  input  logic                    cptra_rst_b,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [15:0]             rsp_latency,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [2:0]              r_pprot;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic                    r_rsp_valid;
  rsp_t                    r_rsp;

  logic                    w_tmr_clr;
  logic                    w_tmr_en;
  logic                    w_limit;
  logic [LAT_W-1:0]        w_lat;

  // Counters clear during SETUP so they read zero on the first ACCESS cycle.
  assign w_tmr_clr = (r_state == ST_SETUP);
  assign w_tmr_en  = (r_state == ST_ACCESS) && !PREADY;

  cptra_apb_init_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk          (core_clk),
    .rst_n        (cptra_rst_b),
    .i_clr        (w_tmr_clr),
    .i_en         (w_tmr_en),
    .o_limit_c    (w_limit),
    .o_lat_next_c (w_lat)
  );

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      r_state     <= ST_IDLE;
      r_paddr     <= '0;
      r_pprot     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_paddr  <= req_addr;
            r_pprot  <= req_prot;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_pstrb  <= '1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY takes priority over a coincident timeout.
          if (PREADY) begin
            r_rsp.rdata   <= r_pwrite ? '0 : DEF_DATA_WIDTH'(PRDATA);
            r_rsp.slverr  <= PSLVERR;
            r_rsp.timeout <= 1'b0;
            r_rsp.latency <= w_lat;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pstrb       <= '0;
            r_state       <= ST_RESP;
          end else if (w_limit) begin
            r_rsp.rdata   <= '0;
            r_rsp.slverr  <= 1'b1;
            r_rsp.timeout <= 1'b1;
            r_rsp.latency <= w_lat;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pstrb       <= '0;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);

  assign PADDR       = r_paddr;
  assign PPROT       = r_pprot;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = DATA_WIDTH'(r_rsp.rdata);
  assign rsp_slverr  = r_rsp.slverr;
  assign rsp_timeout = r_rsp.timeout;
  assign rsp_latency = r_rsp.latency;

endmodule
